// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART image loader that fills SRAM and releases core reset after checksum
module uart_boot_loader #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned MaxWords       = 16384
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  input  logic        uart_rx_i,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        error_o
);
  localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(ClksPerBit / 2 - 1);
  localparam logic [15:0] MaxLen = 16'(MaxWords);
  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR} state_e;

  rx_state_e       rx_state;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CntW-1:0] rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift, rx_byte;
  logic            rx_valid, rx_ferr;

  state_e      state, state_next;
  logic [7:0]  len_lo, csum;
  logic [15:0] len_full, words_left;
  logic [1:0]  byte_idx;
  logic [31:0] word, addr;
  logic        core_rst;

  assign len_full    = {rx_byte, len_lo};
  assign mem_addr_o  = addr;
  assign mem_wdata_o = word;
  assign mem_be_o    = 4'hF;
  assign core_rst_o  = core_rst;

  // Two-flop synchroniser on the asynchronous line, plus one more stage for falling-edge detection
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Byte receiver: half-bit start recheck rejects glitches, then mid-bit sampling of data and stop
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HalfEnd) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BitEnd) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame state register
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) state <= S_SYNC;
    else           state <= state_next;
  end

  // Frame sequencing and status outputs; a framing error aborts everything except a finished load
  always_comb begin
    state_next = state;
    mem_req_o  = (state == S_WRITE);
    done_o     = (state == S_DONE);
    error_o    = (state == S_ERROR);
    if (rx_ferr && state != S_DONE) begin
      state_next = S_ERROR;
    end else begin
      case (state)
        S_SYNC, S_ERROR: if (rx_valid && rx_byte == SyncByte) state_next = S_LEN0;
        S_LEN0:          if (rx_valid) state_next = S_LEN1;
        S_LEN1: begin
          if (rx_valid) begin
            if (len_full > MaxLen)      state_next = S_ERROR;
            else if (len_full == 16'd0) state_next = S_CSUM;
            else                        state_next = S_DATA;
          end
        end
        S_DATA:  if (rx_valid && byte_idx == 2'd3) state_next = S_WRITE;
        S_WRITE: begin
          if (rx_valid)       state_next = S_ERROR;
          else if (mem_gnt_i) state_next = (words_left == 16'd1) ? S_CSUM : S_DATA;
        end
        S_CSUM:  if (rx_valid) state_next = (rx_byte == csum) ? S_DONE : S_ERROR;
        S_DONE:  state_next = S_DONE;
        default: state_next = S_SYNC;
      endcase
    end
  end

  // Word assembly, running checksum, word count and write address
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      len_lo     <= '0;
      csum       <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word       <= '0;
      addr       <= BaseAddr;
    end else begin
      case (state)
        S_SYNC, S_ERROR: begin
          if (rx_valid && rx_byte == SyncByte) begin
            csum     <= '0;
            byte_idx <= '0;
            addr     <= BaseAddr;
          end
        end
        S_LEN0: if (rx_valid) len_lo <= rx_byte;
        S_LEN1: begin
          if (rx_valid) begin
            words_left <= len_full;
            byte_idx   <= '0;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= rx_byte;
            csum     <= csum ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          if (mem_gnt_i && !rx_valid && !rx_ferr) begin
            addr       <= addr + 32'd4;
            words_left <= words_left - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Core is released one cycle after the load completes
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) core_rst <= 1'b1;
    else           core_rst <= (state != S_DONE);
  end
endmodule
